trace_capture: RTL
==================

Name: trace_capture

Overview:
Acquisition stage that sits directly upstream of the four-trace display generator. It samples the 4-bit test inputs at a programmable rate and waits for a selected edge on a selected channel. On that trigger it stores a 640-sample window into an internal buffer. The display side reads the buffer by column (pixel_x), so the screen shows a stable, triggered snapshot instead of live pins.

Parameters:
DEPTH, 640, number of samples per capture (one per display column)
ADDR_W, 10, address width; must satisfy 2^ADDR_W >= DEPTH
DIV_W, 8, width of sample-rate divider input

Ports:
clk  input  1  system clock (25 MHz pixel clock domain)
rst  input  1  synchronous, active-high reset
in  input  4  asynchronous trace inputs
arm  input  1  single-cycle pulse; start a new acquisition
trig_ch  input  2  channel index used for trigger detection
trig_edge  input  1  0 = rising edge, 1 = falling edge
div  input  DIV_W  sample period = div+1 clk cycles
rd_addr  input  ADDR_W  buffer read address (display column)
rd_data  output  4  registered buffer read data
busy  output  1  high in ARMED or CAPTURE
done  output  1  high in DONE; buffer holds a complete window

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE; busy=0; done=0; rd_data=0; write pointer=0; divider counter=0; synchronizer and previous-sample registers=0. Buffer contents are not cleared.
- Input path: `in` passes through a 2-FF synchronizer. The result is the sample `s`. There are 2 clk cycles of latency from pin to `s`.
- Sample tick: the divider counter counts 0..div and then wraps to 0. `tick`=1 on the cycle the counter equals div. With div=0, tick fires every cycle. A change to div takes effect at the next wrap. The counter runs in all states.
- prev register: loaded with `s` on every tick.
- States:
  - IDLE: busy=0, done=0. If arm=1, go to ARMED and load prev<=s. Loading prev at arm suppresses a false edge.
  - ARMED: busy=1. On tick, the trigger fires when trig_edge=0 and prev[trig_ch]=0 and s[trig_ch]=1, or when trig_edge=1 and prev[trig_ch]=1 and s[trig_ch]=0. On trigger: write s to address 0, set pointer=1, go to CAPTURE. With no tick, there is no trigger evaluation.
  - CAPTURE: busy=1. On tick, write s to address pointer and increment pointer. When the write to address DEPTH-1 occurs, go to DONE on the next cycle and set pointer=0.
  - DONE: busy=0, done=1. Contents stay frozen. If arm=1, go to ARMED and done=0 on the next cycle.
- Arm handling: arm during ARMED or CAPTURE is ignored. Acquisition cannot be restarted mid-capture except by rst.
- Trigger config: trig_ch and trig_edge are evaluated live during ARMED and are don't-care in other states.
- Read port: rd_data <= buf[rd_addr] every cycle, independent of state, with 1-cycle latency. If rd_addr >= DEPTH, rd_data=0 on the following cycle.
- Simultaneous read and write to the same address: rd_data returns the old contents (read-first).
- Reset mid-capture: state returns to IDLE. Partially written buffer data remains readable. done=0.
- Buffer: inferred single-port-write / single-port-read RAM, DEPTH x 4.

Optional Feature:
- Macro: TRACE_AUTO_TRIG_EN.
- Defined: a 16-bit timeout counter clears on entry to ARMED and increments on each tick in ARMED. When it reaches 65535 without a trigger, the block forces a trigger on that tick: it writes s to address 0 and goes to CAPTURE, behaving as a normal trigger. This keeps the display updating on static inputs.
- Not defined: ARMED waits indefinitely for an edge, and the counter logic is absent.

Test Plan:
- Reset then idle: hold rst 2 cycles, release -> busy=0, done=0, rd_data=0; arm never pulsed -> state stays IDLE for 1000 cycles.
- Rising trigger, div=0: arm, trig_ch=0, trig_edge=0, drive in[0] square of period 250 clk, in[3:1] static -> done rises exactly 639 cycles after the first buffer write; buf[0][0]=1; buf[1..124][0]=1; buf[125][0]=0 (to within the 2-cycle synchronizer alignment).
- Falling trigger on ch 2, div=3: arm, in[2] falls at time T -> capture spans 640x4=2560 clk; buf[0][2]=0; no write occurs before the falling edge; busy=1 from arm until done.
- Ignored rearm / re-arm: pulse arm mid-CAPTURE -> no restart, pointer unaffected. After done=1, pulse arm -> done=0 next cycle, busy=1, and a new capture overwrites address 0 on the next trigger.
- Read port: after done, rd_addr=0..639 -> rd_data matches the written samples with 1-cycle lag; rd_addr=700 -> rd_data=0.
- With TRACE_AUTO_TRIG_EN, div=0, inputs static: arm -> CAPTURE is entered after 65535 ticks and done is asserted 639 cycles later. Without the macro, the same stimulus leaves busy=1 and done=0 after 100000 cycles.

Source files
------------

// File: rtl/trace_capture.sv
// trace_capture: samples four trace inputs every div+1 clocks, waits for a chosen edge, then stores a DEPTH-sample window for column readout.
// Optional macro TRACE_AUTO_TRIG_EN: forces a trigger after 65535 ticks in ARMED without an edge.
module trace_capture #(
   parameter int DEPTH  = 640,
   parameter int ADDR_W = 10,
   parameter int DIV_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        in,
   input  logic              arm,
   input  logic [1:0]        trig_ch,
   input  logic              trig_edge,
   input  logic [DIV_W-1:0]  div,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [3:0]        rd_data,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

   state_t            state;
   logic [3:0]        sync1;
   logic [3:0]        s;
   logic [3:0]        prev;
   logic [DIV_W-1:0]  cnt;
   logic [DIV_W-1:0]  div_q;
   logic [ADDR_W-1:0] ptr;
   logic              tick;
   logic              edge_hit;
   logic              trig_fire;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [3:0]        mem [DEPTH];
`ifdef TRACE_AUTO_TRIG_EN
   logic [15:0]       to_cnt;
`endif

   always_comb begin
      tick      = (cnt == div_q);
      edge_hit  = trig_edge ? (prev[trig_ch] & ~s[trig_ch])
                            : (~prev[trig_ch] & s[trig_ch]);
      trig_fire = edge_hit;
`ifdef TRACE_AUTO_TRIG_EN
      // this tick is the 65535th one spent waiting
      if (to_cnt == 16'hFFFE) trig_fire = 1'b1;
`endif
      wr_en   = 1'b0;
      wr_addr = ptr;
      if (!rst && tick) begin
         if (state == ARMED && trig_fire) begin
            wr_en   = 1'b1;
            wr_addr = '0;
         end else if (state == CAPTURE) begin
            wr_en = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         ptr   <= '0;
         cnt   <= '0;
         div_q <= div;
         sync1 <= '0;
         s     <= '0;
         prev  <= '0;
`ifdef TRACE_AUTO_TRIG_EN
         to_cnt <= '0;
`endif
      end else begin
         sync1 <= in;
         s     <= sync1;
         // a new divisor is only picked up when the counter wraps
         if (tick) begin
            cnt   <= '0;
            div_q <= div;
            prev  <= s;
         end else begin
            cnt <= cnt + 1'b1;
         end
         case (state)
            IDLE: begin
               if (arm) begin
                  state <= ARMED;
                  busy  <= 1'b1;
                  prev  <= s;
`ifdef TRACE_AUTO_TRIG_EN
                  to_cnt <= '0;
`endif
               end
            end
            ARMED: begin
               if (tick) begin
                  if (trig_fire) begin
                     state <= CAPTURE;
                     ptr   <= ADDR_W'(1);
                  end
`ifdef TRACE_AUTO_TRIG_EN
                  to_cnt <= to_cnt + 1'b1;
`endif
               end
            end
            CAPTURE: begin
               if (tick) begin
                  if (ptr == LAST) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     ptr   <= '0;
                  end else begin
                     ptr <= ptr + 1'b1;
                  end
               end
            end
            DONE: begin
               if (arm) begin
                  state <= ARMED;
                  busy  <= 1'b1;
                  done  <= 1'b0;
                  prev  <= s;
`ifdef TRACE_AUTO_TRIG_EN
                  to_cnt <= '0;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // buffer is deliberately left out of reset so partial captures stay readable
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= s;
   end

   always_ff @(posedge clk) begin
      if (rst) rd_data <= '0;
      else     rd_data <= (rd_addr <= LAST) ? mem[rd_addr] : 4'h0;
   end

endmodule
